// File: rtl/bht_update_ctrl_if.sv
// Retire, PHT-write and history-read signal bundle for bht_update_ctrl.
// master drives retires/lookups; slave is the update controller.
interface bht_update_ctrl_if #(
    parameter int HISTLEN = 10
);
    logic               ret_vld_i;
    logic               ret_rdy_o;
    logic [63:0]        ret_pc_i;
    logic               ret_taken_i;
    logic               ret_mispred_i;
    logic               pht_wr_rdy_i;
    logic [HISTLEN-1:0] pht_wt_index_o;
    logic               pht_cm_brdir_we_o;
    logic               pht_cm_brdir_o;
    logic [63:0]        hist_rd_pc_i;
    logic [HISTLEN-1:0] hist_rd_o;

    modport master (
        output ret_vld_i, ret_pc_i, ret_taken_i, ret_mispred_i,
        output pht_wr_rdy_i, hist_rd_pc_i,
        input  ret_rdy_o, pht_wt_index_o, pht_cm_brdir_we_o,
        input  pht_cm_brdir_o, hist_rd_o
    );

    modport slave (
        input  ret_vld_i, ret_pc_i, ret_taken_i, ret_mispred_i,
        input  pht_wr_rdy_i, hist_rd_pc_i,
        output ret_rdy_o, pht_wt_index_o, pht_cm_brdir_we_o,
        output pht_cm_brdir_o, hist_rd_o
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// Local-history BHT update controller: retire FIFO feeding PHT writes.
// Optional perf counters enabled by macro BHT_UPD_PERF_CNT_EN.
module bht_update_ctrl #(
    parameter int DEPTH   = 8,
    parameter int HISTLEN = 10,
    parameter int BHTENT  = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    bht_update_ctrl_if.slave   bus,
    output logic               init_busy_o
`ifdef BHT_UPD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_br_cnt_o,
    output logic [31:0]        perf_mispred_cnt_o
`endif
);
    localparam int BIDX = $clog2(BHTENT);
    localparam int PW   = $clog2(DEPTH);
    localparam logic [BIDX-1:0] LAST = BIDX'(BHTENT - 1);
    localparam logic [PW:0]     FULL = (PW + 1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [BIDX-1:0] idx;
        logic            taken;
        logic            mispred;
    } ent_t;

    state_t             state;
    logic [BIDX-1:0]    clr_idx;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [PW:0]        count;
    logic [HISTLEN-1:0] wt_idx_q;
    logic               we_q;
    logic               dir_q;

    ent_t               q [DEPTH];
    logic [HISTLEN-1:0] bht [BHTENT];

    ent_t               head;
    logic [HISTLEN-1:0] h;
    logic               push;
    logic               pop;
    logic               bht_we;
    logic [BIDX-1:0]    bht_wa;
    logic [HISTLEN-1:0] bht_wd;
    logic [BIDX-1:0]    hist_idx;
    logic               unused_bits;

    // ready depends only on registered state, never on pht_wr_rdy_i
    assign bus.ret_rdy_o = (state == RUN) && (count != FULL);
    assign push = bus.ret_vld_i & bus.ret_rdy_o;
    assign pop  = (state == RUN) && (count != '0) && bus.pht_wr_rdy_i;

    assign head = q[rptr];
    assign h    = bht[head.idx];

    assign bus.pht_wt_index_o    = wt_idx_q;
    assign bus.pht_cm_brdir_we_o = we_q;
    assign bus.pht_cm_brdir_o    = dir_q;
    assign init_busy_o           = (state == INIT);

    assign hist_idx      = bus.hist_rd_pc_i[BIDX+1:2];
    assign bus.hist_rd_o = (state == INIT) ? '0 : bht[hist_idx];

    assign unused_bits = ^{bus.ret_pc_i[63:BIDX+2], bus.ret_pc_i[1:0],
                           bus.hist_rd_pc_i[63:BIDX+2],
                           bus.hist_rd_pc_i[1:0], head.mispred};

    always_comb begin
        bht_we = 1'b0;
        bht_wa = clr_idx;
        bht_wd = '0;
        if (state == INIT) begin
            bht_we = 1'b1;
        end else if (pop) begin
            bht_we = 1'b1;
            bht_wa = head.idx;
            bht_wd = {h[HISTLEN-2:0], head.taken};
        end
    end

    // Tables carry no reset; the BHT is zeroed by the INIT sweep
    always_ff @(posedge clock) begin
        if (bht_we)
            bht[bht_wa] <= bht_wd;
        if (push)
            q[wptr] <= '{idx:     bus.ret_pc_i[BIDX+1:2],
                         taken:   bus.ret_taken_i,
                         mispred: bus.ret_mispred_i};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            clr_idx  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wt_idx_q <= '0;
            we_q     <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            we_q <= pop;
            unique case (state)
                INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST)
                        state <= RUN;
                end
                RUN: begin
                    if (push)
                        wptr <= wptr + 1'b1;
                    if (pop) begin
                        rptr     <= rptr + 1'b1;
                        wt_idx_q <= h;
                        dir_q    <= head.taken;
                    end
                    unique case ({push, pop})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef BHT_UPD_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_br_cnt_o      <= '0;
            perf_mispred_cnt_o <= '0;
        end else if (pop) begin
            perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
            if (head.mispred)
                perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: stimulus pushes expected PHT
// writes, a monitor pops and compares on every write strobe.
module tb_bht_update_ctrl;
    localparam int HL = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic init_busy_o;
`ifdef BHT_UPD_PERF_CNT_EN
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_mispred_cnt_o;
`endif

    bht_update_ctrl_if #(.HISTLEN(HL)) bus();

    bht_update_ctrl #(
        .DEPTH(8), .HISTLEN(HL), .BHTENT(1024)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave),
        .init_busy_o(init_busy_o)
`ifdef BHT_UPD_PERF_CNT_EN
        ,
        .perf_br_cnt_o(perf_br_cnt_o),
        .perf_mispred_cnt_o(perf_mispred_cnt_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [HL-1:0] idx;
        logic          dir;
    } exp_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] pc, input logic t,
                        input logic m, input bit pe,
                        input logic [HL-1:0] ei, input logic ed);
        int n;
        n = 0;
        @(negedge clock);
        while (bus.ret_rdy_o !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("send_rdy", 64'(bus.ret_rdy_o), 64'd1);
        bus.ret_pc_i      = pc;
        bus.ret_taken_i   = t;
        bus.ret_mispred_i = m;
        bus.ret_vld_i     = 1'b1;
        if (pe)
            sb.push_back('{idx: ei, dir: ed});
        @(posedge clock);
        #1;
        bus.ret_vld_i = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        chk({tag, "_rst_rdy"}, 64'(bus.ret_rdy_o), 64'd0);
        chk({tag, "_rst_idx"}, 64'(bus.pht_wt_index_o), 64'd0);
        chk({tag, "_rst_we"}, 64'(bus.pht_cm_brdir_we_o), 64'd0);
        chk({tag, "_rst_dir"}, 64'(bus.pht_cm_brdir_o), 64'd0);
        chk({tag, "_rst_busy"}, 64'(init_busy_o), 64'd1);
        chk({tag, "_rst_hist"}, 64'(bus.hist_rd_o), 64'd0);
`ifdef BHT_UPD_PERF_CNT_EN
        chk({tag, "_rst_pbr"}, 64'(perf_br_cnt_o), 64'd0);
        chk({tag, "_rst_pmis"}, 64'(perf_mispred_cnt_o), 64'd0);
`endif
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        @(negedge clock);
        while (init_busy_o && n < 2000) begin
            n++;
            if (bus.ret_rdy_o !== 1'b0)
                bad++;
            @(negedge clock);
        end
        chk({tag, "_init_cycles"}, 64'(n), 64'd1024);
        chk({tag, "_init_rdy_low"}, 64'(bad), 64'd0);
        chk({tag, "_run_rdy"}, 64'(bus.ret_rdy_o), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic hist(input string tag, input logic [63:0] pc,
                        input logic [HL-1:0] e);
        bus.hist_rd_pc_i = pc;
        #1;
        chk(tag, 64'(bus.hist_rd_o), 64'(e));
    endtask

    initial begin
        bus.ret_vld_i     = 1'b0;
        bus.ret_pc_i      = '0;
        bus.ret_taken_i   = 1'b0;
        bus.ret_mispred_i = 1'b0;
        bus.pht_wr_rdy_i  = 1'b0;
        bus.hist_rd_pc_i  = '0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clock);
                    if (bus.pht_cm_brdir_we_o === 1'b1) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_wr",
                                64'(bus.pht_cm_brdir_we_o), 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("wr_index", 64'(bus.pht_wt_index_o),
                                64'(e.idx));
                            chk("wr_dir", 64'(bus.pht_cm_brdir_o),
                                64'(e.dir));
                        end
                    end
                end
            end
            begin : stim
                int s;
                // power-on clear with a retire held pending throughout
                do_reset("por");
                bus.ret_vld_i = 1'b1;
                bus.ret_pc_i  = 64'h40;
                wait_init("por");
                bus.ret_vld_i = 1'b0;
                chk("run_busy", 64'(init_busy_o), 64'd0);

                // same entry three times: history 0 -> 1 -> 3 -> 7
                bus.pht_wr_rdy_i = 1'b1;
                send(64'h1004, 1, 0, 1, 10'h000, 1);
                send(64'h1004, 1, 0, 1, 10'h001, 1);
                send(64'h1004, 1, 0, 1, 10'h003, 1);
                drain("t3");
                chk("idx_hold", 64'(bus.pht_wt_index_o), 64'h3);
                chk("dir_hold", 64'(bus.pht_cm_brdir_o), 64'd1);
                hist("hist_1004_a", 64'h1004, 10'h007);

                // single retire latency and one-cycle pulse
                send(64'h1008, 1, 0, 1, 10'h000, 1);
                @(negedge clock);
                chk("lat_early", 64'(bus.pht_cm_brdir_we_o), 64'd0);
                @(negedge clock);
                chk("lat_strobe", 64'(bus.pht_cm_brdir_we_o), 64'd1);
                @(negedge clock);
                chk("lat_pulse", 64'(bus.pht_cm_brdir_we_o), 64'd0);
                hist("hist_1008", 64'h1008, 10'h001);

                // fill with PHT port blocked, ninth retire refused
                bus.pht_wr_rdy_i = 1'b0;
                send(64'h1004, 0, 0, 1, 10'h007, 0);
                send(64'h0100, 1, 0, 1, 10'h000, 1);
                send(64'h1004, 1, 0, 1, 10'h00e, 1);
                send(64'h0100, 1, 0, 1, 10'h001, 1);
                send(64'h0104, 0, 0, 1, 10'h000, 0);
                send(64'h0100, 0, 0, 1, 10'h003, 0);
                send(64'h1004, 1, 0, 1, 10'h01d, 1);
                send(64'h0108, 1, 0, 1, 10'h000, 1);
                @(negedge clock);
                chk("full_rdy", 64'(bus.ret_rdy_o), 64'd0);
                chk("blocked_we", 64'(bus.pht_cm_brdir_we_o), 64'd0);
                hist("hist_blocked", 64'h1004, 10'h007);
                bus.ret_pc_i  = 64'h010c;
                bus.ret_vld_i = 1'b1;
                @(posedge clock);
                #1;
                bus.ret_vld_i    = 1'b0;
                bus.pht_wr_rdy_i = 1'b1;
                @(posedge clock);
                s = 0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    if (bus.pht_cm_brdir_we_o === 1'b1)
                        s++;
                end
                chk("burst_cnt", 64'(s), 64'd8);
                @(negedge clock);
                chk("burst_end", 64'(bus.pht_cm_brdir_we_o), 64'd0);
                drain("t8");
                hist("hist_1004_b", 64'h1004, 10'h03b);
                hist("hist_0100", 64'h0100, 10'h006);

                // full queue with pop and pending retire in the same cycle
                bus.pht_wr_rdy_i = 1'b0;
                for (int i = 0; i < 8; i++)
                    send(64'h200 + 64'(4 * i), 1, 0, 1, 10'h000, 1);
                bus.pht_wr_rdy_i = 1'b1;
                bus.ret_pc_i     = 64'h200;
                bus.ret_taken_i  = 1'b0;
                bus.ret_vld_i    = 1'b1;
                sb.push_back('{idx: 10'h001, dir: 1'b0});
                @(negedge clock);
                chk("stall_rdy", 64'(bus.ret_rdy_o), 64'd0);
                @(negedge clock);
                chk("reopen_rdy", 64'(bus.ret_rdy_o), 64'd1);
                @(posedge clock);
                #1;
                bus.ret_vld_i = 1'b0;
                drain("t9");

                // reset halfway through the clear sweep
                do_reset("mid");
                bus.hist_rd_pc_i = 64'h1004;
                repeat (500) @(negedge clock);
                chk("mid_busy", 64'(init_busy_o), 64'd1);
                chk("mid_hist", 64'(bus.hist_rd_o), 64'd0);
                do_reset("mid2");
                wait_init("mid2");
                hist("hist_cleared", 64'h1004, 10'h000);

                // queued entries dropped by reset, never written
                bus.pht_wr_rdy_i = 1'b0;
                for (int i = 0; i < 5; i++)
                    send(64'h1004, 1, 0, 0, 10'h000, 0);
                bus.pht_wr_rdy_i = 1'b1;
                do_reset("q5");
                wait_init("q5");
                repeat (3) @(negedge clock);
                chk("q5_no_wr", 64'(bus.pht_cm_brdir_we_o), 64'd0);
                hist("q5_hist", 64'h1004, 10'h000);

                // four retires, one mispredicted
                send(64'h1004, 1, 0, 1, 10'h000, 1);
                send(64'h1004, 0, 1, 1, 10'h001, 0);
                send(64'h0300, 1, 0, 1, 10'h000, 1);
                send(64'h1004, 1, 0, 1, 10'h002, 1);
                drain("perf");
                hist("perf_hist", 64'h1004, 10'h005);
`ifdef BHT_UPD_PERF_CNT_EN
                chk("perf_br", 64'(perf_br_cnt_o), 64'd4);
                chk("perf_mis", 64'(perf_mispred_cnt_o), 64'd1);
`endif
            end
            begin : watchdog
                repeat (50000) @(negedge clock);
                errs++;
                checks++;
                $display("FAIL watchdog: got timeout expected completion");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning retire-queue entries (power of 2).
REQ-002 SHALL have parameter HISTLEN, default 10, meaning local-history width and PHT write-index width.
REQ-003 SHALL have parameter BHTENT, default 1024, meaning local-history-table entries, indexed by pc[11:2].
REQ-004 SHALL have ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- ret_vld_i  in  1  retired conditional branch valid
- ret_rdy_o  out  1  retire queue can accept
- ret_pc_i  in  64  retired branch PC
- ret_taken_i  in  1  resolved direction
- ret_mispred_i  in  1  branch was mispredicted
- pht_wr_rdy_i  in  1  PHT write port free this cycle
- pht_wt_index_o  out  HISTLEN  PHT entry to update
- pht_cm_brdir_we_o  out  1  PHT update strobe
- pht_cm_brdir_o  out  1  direction written to PHT
- hist_rd_pc_i  in  64  fetch PC for history lookup
- hist_rd_o  out  HISTLEN  local history for the fetch-side PHT read index
- init_busy_o  out  1  table clear in progress

Function
REQ-005 SHALL implement a two-state FSM, INIT and RUN; INIT is entered on reset.
REQ-006 In INIT, SHALL write zero to one BHT entry per cycle, indices 0..BHTENT-1 ascending, then enter RUN on the cycle after writing entry BHTENT-1 (BHTENT cycles total).
REQ-007 init_busy_o SHALL be 1 in INIT and 0 in RUN.
REQ-008 ret_rdy_o SHALL be 1 only in RUN with occupancy < DEPTH, computed from registered state only (no combinational path from pht_wr_rdy_i).
REQ-009 Enqueue SHALL occur on a clock edge with ret_vld_i & ret_rdy_o, storing {pc[11:2], taken, mispred}; ret_vld_i without ret_rdy_o SHALL be ignored.
REQ-010 The queue SHALL be FIFO-ordered, with wrap-around pointers over DEPTH entries.
REQ-011 Pop SHALL occur on an edge with RUN, queue non-empty and pht_wr_rdy_i=1; at most one pop per cycle.
REQ-012 On pop edge, with h = BHT[idx]:
- pht_wt_index_o <= h
- pht_cm_brdir_o <= taken
- pht_cm_brdir_we_o <= 1
- BHT[idx] <= {h[HISTLEN-2:0], taken}
REQ-013 pht_cm_brdir_we_o SHALL be a one-cycle pulse, 0 in any cycle following a non-pop edge; index and dir hold their last value when strobe is 0.
REQ-014 Latency: a branch accepted at edge t with empty queue and pht_wr_rdy_i=1 SHALL produce the strobe in the cycle after edge t+1.
REQ-015 Back-to-back pops to the same idx SHALL see the history written by the prior pop (no stale read).
REQ-016 Simultaneous enqueue and pop SHALL leave occupancy unchanged; enqueue into a full queue is impossible (REQ-008).
REQ-017 hist_rd_o SHALL equal BHT[hist_rd_pc_i[11:2]], combinationally, returning the pre-write value on a same-cycle BHT write, and 0 while in INIT.

Reset
REQ-018 Asserting reset_n low SHALL immediately clear occupancy, pointers, all outputs (ret_rdy_o=0, pht_wt_index_o=0, pht_cm_brdir_we_o=0, pht_cm_brdir_o=0), set init_busy_o=1 and state INIT with clear index 0.
REQ-019 Reset during INIT SHALL restart the clear from index 0; queued entries SHALL be discarded without PHT writes.
REQ-020 The BHT array SHALL NOT be asynchronously reset; it is cleared only by INIT.

Configuration
REQ-021 With macro BHT_UPD_PERF_CNT_EN defined, SHALL add outputs perf_br_cnt_o[31:0] and perf_mispred_cnt_o[31:0], incremented on each pop (the latter when mispred=1), wrapping at 2^32, reset to 0.
REQ-022 Without BHT_UPD_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Reset, hold ret_vld_i=1 -> init_busy_o=1 and ret_rdy_o=0 for exactly 1024 cycles, then ret_rdy_o=1.
REQ-024 After INIT, retire pc=0x1004, taken=1 three times, pht_wr_rdy_i=1 -> PHT writes index 0x000, 0x001, 0x003; then hist_rd_pc_i=0x1004 -> hist_rd_o=0x007.
REQ-025 pht_wr_rdy_i=0, retire 9 branches -> 8 accepted, ret_rdy_o=0 on the 9th; raise pht_wr_rdy_i -> 8 strobes in FIFO order on consecutive cycles.
REQ-026 Full queue with pht_wr_rdy_i=1 and ret_vld_i=1 -> ret_rdy_o stays 0 that cycle, returns 1 next cycle, occupancy never exceeds 8.
REQ-027 Reset at cycle 500 of INIT, and separately with 5 queued entries -> clear restarts at index 0, no PHT strobe emitted, all outputs 0.
REQ-028 With BHT_UPD_PERF_CNT_EN, retire 4 branches with 1 mispredicted -> perf_br_cnt_o=4, perf_mispred_cnt_o=1.
